// File: rtl/cache_mem_pkg.sv
// Shared types and geometry helpers for the cache miss path and its memory-side responder.
package cache_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD_BURST,
    WR_BURST,
    WR_COMMIT
  } srv_state_e;

  localparam int unsigned REQ_ADDR_WIDTH = 32;

  typedef struct packed {
    logic                      write;
    logic [REQ_ADDR_WIDTH-1:0] addr;
  } cache_req_t;

  function automatic int unsigned words_per_line(input int unsigned block_bytes);
    return block_bytes / 4;
  endfunction

  function automatic int unsigned offset_width(input int unsigned block_bytes);
    return $clog2(block_bytes);
  endfunction

  function automatic int unsigned line_index_width(input int unsigned mem_lines);
    return $clog2(mem_lines);
  endfunction

endpackage

// File: rtl/cache_line_server_line_wrap_counter.sv
// Beat counter for one line burst: word index starts at 'start' and wraps within the line.
module line_wrap_counter #(
  parameter int unsigned WPL = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [$clog2(WPL)-1:0] start,
  input  logic                   load,
  input  logic                   advance,
  output logic [$clog2(WPL)-1:0] index,
  output logic                   last
);

  localparam int unsigned IW = $clog2(WPL);
  localparam int unsigned BW = IW + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(WPL - 1);

  logic [IW-1:0] start_q;
  logic [BW-1:0] beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= '0;
      beat    <= '0;
    end else if (load) begin
      start_q <= start;
      beat    <= '0;
    end else if (advance) begin
      beat <= beat + 1'b1;
    end
  end

  // Truncation to IW bits keeps the index inside the line.
  assign index = IW'(start_q + beat[IW-1:0]);
  assign last  = (beat == LAST_BEAT);

endmodule

// File: rtl/cache_line_server.sv
// Memory-side responder: serves critical-word-first line refills and line writebacks
// from a word-addressed backing store with a fixed access latency.
module cache_line_server
  import cache_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned BLOCK_SIZE_BYTES = 64,
  parameter int unsigned MEM_LINES        = 1024,
  parameter int unsigned LATENCY          = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [31:0]           wr_data,
  output logic                  wr_done,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic                  rsp_last
);

  localparam int unsigned WPL    = words_per_line(BLOCK_SIZE_BYTES);
  localparam int unsigned OFFSET = offset_width(BLOCK_SIZE_BYTES);
  localparam int unsigned IW     = $clog2(WPL);
  localparam int unsigned LIW    = line_index_width(MEM_LINES);
  localparam int unsigned LW     = (LATENCY == 0) ? 1 : $clog2(LATENCY + 1);
  localparam logic [LW-1:0] WAIT_LAST   = LW'(LATENCY - 1);
  localparam logic [LW-1:0] COMMIT_LAST = LW'(LATENCY);

  srv_state_e state, state_next;

  logic [LW-1:0]  lat_cnt;
  logic [LIW-1:0] line_q, req_line, rd_line;
  logic [IW-1:0]  req_start, word_idx, rd_word;
  logic           word_last;
  logic           accept, rd_fire, wr_fire, load_rd;
  logic [31:0]    mem [MEM_LINES*WPL];
  logic           unused_addr_bits;

  assign req_line         = req_addr[OFFSET+LIW-1:OFFSET];
  assign req_start        = req_addr[OFFSET-1:2];
  assign unused_addr_bits = ^{req_addr[ADDR_WIDTH-1:OFFSET+LIW], req_addr[1:0]};

  line_wrap_counter #(
    .WPL(WPL)
  ) u_wrap (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (req_start),
    .load   (accept),
    .advance(rd_fire || wr_fire),
    .index  (word_idx),
    .last   (word_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    wr_ready   = 1'b0;
    wr_done    = 1'b0;
    rsp_valid  = 1'b0;
    rsp_last   = 1'b0;
    accept     = 1'b0;
    rd_fire    = 1'b0;
    wr_fire    = 1'b0;
    rd_line    = line_q;
    rd_word    = word_idx;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
        rd_line   = req_line;
        rd_word   = req_start;
        if (req_valid) begin
          state_next = req_write ? WR_BURST : ((LATENCY == 0) ? RD_BURST : WAIT);
        end
      end
      WAIT: begin
        if (lat_cnt == WAIT_LAST) state_next = RD_BURST;
      end
      RD_BURST: begin
        rsp_valid = 1'b1;
        rsp_last  = word_last;
        rd_fire   = rsp_ready;
        rd_word   = IW'(word_idx + 1'b1);
        if (rsp_ready && word_last) state_next = IDLE;
      end
      WR_BURST: begin
        wr_ready = 1'b1;
        wr_fire  = wr_valid;
        if (wr_valid && word_last) state_next = WR_COMMIT;
      end
      WR_COMMIT: begin
        if (lat_cnt == COMMIT_LAST) begin
          wr_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Prefetch into rsp_data on burst entry and on every non-final handshake.
    load_rd = ((state != RD_BURST) && (state_next == RD_BURST)) ||
              (rd_fire && !word_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= '0;
    end else if (state_next != state) begin
      lat_cnt <= '0;
    end else if ((state == WAIT) || (state == WR_COMMIT)) begin
      lat_cnt <= lat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else if (accept) begin
      line_q <= req_line;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
    end else if (load_rd) begin
      rsp_data <= mem[{rd_line, rd_word}];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[{line_q, word_idx}] <= wr_data;
  end

endmodule

// File: tb/tb_cache_line_server.sv
// Bench for cache_line_server: table of refill/writeback transactions against a word model,
// read beats scored from a queue, plus reset-mid-burst and zero-latency sequences.
module tb_cache_line_server;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] base;
    logic [3:0]  pat;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_write, wr_valid, wr_ready, wr_done;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [31:0] req_addr, wr_data, rsp_data;
  logic        z_req_valid, z_req_ready, z_req_write, z_wr_valid, z_wr_ready, z_wr_done;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_last;
  logic [31:0] z_req_addr, z_wr_data, z_rsp_data;

  int          checks = 0;
  int          errors = 0;
  beat_t       exp_q[$];
  beat_t       mon_b;
  logic [31:0] model [int];
  logic        stalled = 1'b0;
  logic [31:0] held_data;
  logic        held_last;
  vec_t        vecs [9];

  cache_line_server #(
    .ADDR_WIDTH(32), .BLOCK_SIZE_BYTES(64), .MEM_LINES(1024), .LATENCY(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_done(wr_done), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_last(rsp_last)
  );

  cache_line_server #(
    .ADDR_WIDTH(32), .BLOCK_SIZE_BYTES(64), .MEM_LINES(1024), .LATENCY(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_write(z_req_write), .req_addr(z_req_addr), .wr_valid(z_wr_valid), .wr_ready(z_wr_ready),
    .wr_data(z_wr_data), .wr_done(z_wr_done), .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_data(z_rsp_data), .rsp_last(z_rsp_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void push_line(input logic [31:0] addr);
    int unsigned line = int'(addr[15:6]);
    int unsigned st   = int'(addr[5:2]);
    for (int unsigned k = 0; k < 16; k++) begin
      exp_q.push_back('{data: model[int'(line * 16 + (st + k) % 16)], last: (k == 15)});
    end
  endfunction

  // Read-beat scoreboard and backpressure stability monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stalled && rsp_valid) begin
        check("stall_data", rsp_data, held_data);
        check("stall_last", {31'b0, rsp_last}, {31'b0, held_last});
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat actual=%h required=none", rsp_data);
        end else begin
          mon_b = exp_q.pop_front();
          check("rsp_data", rsp_data, mon_b.data);
          check("rsp_last", {31'b0, rsp_last}, {31'b0, mon_b.last});
        end
      end
      stalled   = rsp_valid && !rsp_ready;
      held_data = rsp_data;
      held_last = rsp_last;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [31:0] base, input int exp_lat);
    int unsigned line = int'(addr[15:6]);
    int unsigned st   = int'(addr[5:2]);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("wr_ready_on", {31'b0, wr_ready}, 32'd1);
    for (int unsigned k = 0; k < 16; k++) begin
      wr_valid = 1'b1;
      wr_data  = base + k;
      model[int'(line * 16 + (st + k) % 16)] = base + k;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    check("wr_ready_off", {31'b0, wr_ready}, 32'd0);
    n = 0;
    while (!wr_done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("wr_done_latency", n, exp_lat);
    @(posedge clk); #1;
    check("wr_done_pulse", {31'b0, wr_done}, 32'd0);
    check("req_ready_after_wr", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] pat, input int exp_lat,
                         input logic [31:0] exp_first, input logic [31:0] exp_last);
    int n;
    int unsigned i;
    push_line(addr);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; rsp_ready = pat[0];
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("rsp_latency", n, exp_lat);
    check("first_word", rsp_data, exp_first);
    i = 0;
    while (exp_q.size() != 0 && i < 100) begin
      if (rsp_valid && rsp_last) check("last_word", rsp_data, exp_last);
      @(posedge clk); #1;
      i++;
      rsp_ready = pat[i % 4];
    end
    check("beats_left", exp_q.size(), 0);
    exp_q.delete();
    check("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
    check("req_ready_after_rd", {31'b0, req_ready}, 32'd1);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] w;
    vecs[0] = '{1'b1, 32'h0000_0140, 32'hA0, 4'b1111, 32'h0,  32'h0};
    vecs[1] = '{1'b0, 32'h0000_0140, 32'h0,  4'b1111, 32'hA0, 32'hAF};
    vecs[2] = '{1'b0, 32'h0000_0158, 32'h0,  4'b1111, 32'hA6, 32'hA5};
    vecs[3] = '{1'b0, 32'h0000_0140, 32'h0,  4'b1001, 32'hA0, 32'hAF};
    vecs[4] = '{1'b1, 32'h0000_017C, 32'hB0, 4'b1111, 32'h0,  32'h0};
    vecs[5] = '{1'b0, 32'h0000_0140, 32'h0,  4'b1111, 32'hB1, 32'hB0};
    vecs[6] = '{1'b0, 32'h0000_017C, 32'h0,  4'b0110, 32'hB0, 32'hBF};
    vecs[7] = '{1'b1, 32'h1000_0080, 32'hC0, 4'b1111, 32'h0,  32'h0};
    vecs[8] = '{1'b0, 32'h0000_0088, 32'h0,  4'b1111, 32'hC2, 32'hC1};

    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; wr_valid = 1'b0; wr_data = '0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_wr_valid = 1'b0; z_wr_data = '0;
    z_rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
    check("rst_wr_done", {31'b0, wr_done}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_last", {31'b0, rsp_last}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int unsigned v = 0; v < 9; v++) begin
      if (vecs[v].write) do_write(vecs[v].addr, vecs[v].base, 4);
      else do_read(vecs[v].addr, vecs[v].pat, 4, vecs[v].exp_first, vecs[v].exp_last);
    end

    // Reset while beat 7 of a refill is on the bus.
    push_line(32'h0000_0140);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0140; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (exp_q.size() > 9 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_beat7_valid", {31'b0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("t6_req_ready", {31'b0, req_ready}, 32'd1);
    check("t6_rsp_data", rsp_data, 32'd0);
    exp_q.delete();
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_read(32'h0000_0140, 4'b1111, 4, 32'hB1, 32'hB0);

    // Zero-latency instance: write line 1, then refill from word 2.
    @(posedge clk); #1;
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h0000_0040;
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    check("t5_wr_ready", {31'b0, z_wr_ready}, 32'd1);
    for (int unsigned k = 0; k < 16; k++) begin
      z_wr_valid = 1'b1;
      z_wr_data  = 32'hD0 + k;
      @(posedge clk); #1;
    end
    z_wr_valid = 1'b0;
    check("t5_wr_done", {31'b0, z_wr_done}, 32'd1);
    @(posedge clk); #1;
    check("t5_wr_done_pulse", {31'b0, z_wr_done}, 32'd0);
    check("t5_req_ready", {31'b0, z_req_ready}, 32'd1);
    z_req_valid = 1'b1; z_req_write = 1'b0; z_req_addr = 32'h0000_0048; z_rsp_ready = 1'b1;
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    for (int unsigned k = 0; k < 16; k++) begin
      w = 32'hD0 + ((2 + k) % 16);
      check("t5_rsp_valid", {31'b0, z_rsp_valid}, 32'd1);
      check("t5_rsp_data", z_rsp_data, w);
      check("t5_rsp_last", {31'b0, z_rsp_last}, {31'b0, (k == 15)});
      @(posedge clk); #1;
    end
    check("t5_rsp_drop", {31'b0, z_rsp_valid}, 32'd0);
    z_rsp_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
